// File: rtl/rsa_frame_sequencer_pkg.sv
// Shared types and constants for the RSA frame sequencer.
// Package rsa_seq_pkg: FSM state encoding, frame geometry, default width
// and the all-ones word returned when an operand frame is rejected.
package rsa_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_CHECK = 3'd2,
        ST_START = 3'd3,
        ST_WAIT  = 3'd4,
        ST_SEND  = 3'd5
    } seq_state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int FRAME_BYTES   = 12;
    localparam int RESULT_BYTES  = 4;

    localparam logic [DEFAULT_WIDTH-1:0] ERROR_WORD = {DEFAULT_WIDTH{1'b1}};

endpackage

// File: rtl/rsa_frame_sequencer_if.sv
// Byte-stream and modexp-core bus of the RSA frame sequencer.
// master: the sequencer side; slave: the uart_rx/uart_tx/core side.
interface rsa_frame_sequencer_if
    import rsa_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             core_start;
    logic [WIDTH-1:0] core_msg;
    logic [WIDTH-1:0] core_exp;
    logic [WIDTH-1:0] core_mod;
    logic             core_done;
    logic [WIDTH-1:0] core_result;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;

    modport master (
        input  rx_valid, rx_data, core_done, core_result, tx_ready,
        output core_start, core_msg, core_exp, core_mod, tx_valid, tx_data
    );

    modport slave (
        output rx_valid, rx_data, core_done, core_result, tx_ready,
        input  core_start, core_msg, core_exp, core_mod, tx_valid, tx_data
    );
endinterface

// File: rtl/rsa_frame_sequencer_gap_timer.sv
// rsa_byte_gap_timer: counts idle cycles between received frame bytes.
// The count saturates at TIMEOUT_CYCLES (never wraps); expire is high
// while the count sits at that limit.
module rsa_byte_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_r;

    // Saturating idle counter; a clear (new byte or leaving RECV) restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = (count_r == LIMIT);

endmodule

// File: rtl/rsa_frame_sequencer.sv
// rsa_frame_sequencer: collects a 3*BYTES operand frame (M, E, N, each
// MSB-first) from uart_rx, runs one modexp transaction on the core and
// returns the result MSB-first through uart_tx.
// Optional build macro RSA_OPERAND_CHECK_EN: reject frames with N==0 or
// M>=N without starting the core, answering with an all-ones word.
module rsa_frame_sequencer
    import rsa_seq_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    rsa_frame_sequencer_if.master bus,
    output logic [WIDTH-1:0]      output_text,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int BYTES     = WIDTH / 8;
    localparam int FRAME_LEN = 3 * BYTES;
    localparam int IDX_W     = $clog2(BYTES + 1);
    localparam logic [3:0]       LAST_BYTE = 4'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_TX   = IDX_W'(BYTES - 1);

    seq_state_t         state_r;
    seq_state_t         state_s;
    logic [3*WIDTH-1:0] frame_r;
    logic [3:0]         byte_cnt_r;
    logic               core_start_r;
    logic [WIDTH-1:0]   core_msg_r;
    logic [WIDTH-1:0]   core_exp_r;
    logic [WIDTH-1:0]   core_mod_r;
    logic [WIDTH-1:0]   output_text_r;
    logic [WIDTH-1:0]   tx_shift_r;
    logic [IDX_W-1:0]   tx_idx_r;
    logic               tx_valid_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic               gap_clear_s;
    logic               gap_enable_s;
    logic               gap_expire_s;
    logic               operand_bad_s;
    logic [WIDTH-1:0]   frame_m_s;
    logic [WIDTH-1:0]   frame_e_s;
    logic [WIDTH-1:0]   frame_n_s;

    assign frame_m_s = frame_r[3*WIDTH-1 -: WIDTH];
    assign frame_e_s = frame_r[2*WIDTH-1 -: WIDTH];
    assign frame_n_s = frame_r[WIDTH-1:0];

`ifdef RSA_OPERAND_CHECK_EN
    assign operand_bad_s = (frame_n_s == {WIDTH{1'b0}}) || (frame_m_s >= frame_n_s);
`else
    assign operand_bad_s = 1'b0;
`endif

    // The gap timer only runs while a frame is being received.
    assign gap_enable_s = (state_r == ST_RECV);
    assign gap_clear_s  = (state_r != ST_RECV) || bus.rx_valid;

    rsa_byte_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk   (clk),
        .reset (reset),
        .clear (gap_clear_s),
        .enable(gap_enable_s),
        .expire(gap_expire_s)
    );

    // State register and the registered busy flag that mirrors it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Next-state logic; a byte on the timeout cycle keeps the frame alive.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.rx_valid && go) state_s = ST_RECV;
                else                    state_s = ST_IDLE;
            end
            ST_RECV: begin
                if (bus.rx_valid) begin
                    if (byte_cnt_r == LAST_BYTE) state_s = ST_CHECK;
                    else                         state_s = ST_RECV;
                end else if (gap_expire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_CHECK: begin
                if (operand_bad_s) state_s = ST_SEND;
                else               state_s = ST_START;
            end
            ST_START: state_s = ST_WAIT;
            ST_WAIT: begin
                if (bus.core_done) state_s = ST_WAIT == ST_WAIT ? ST_SEND : ST_WAIT;
                else               state_s = ST_WAIT;
            end
            ST_SEND: begin
                if (tx_valid_r && bus.tx_ready && (tx_idx_r == LAST_TX)) state_s = ST_IDLE;
                else                                                     state_s = ST_SEND;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Frame assembly, operand/result registers, tx serializer and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_r       <= {(3*WIDTH){1'b0}};
            byte_cnt_r    <= 4'd0;
            core_start_r  <= 1'b0;
            core_msg_r    <= {WIDTH{1'b0}};
            core_exp_r    <= {WIDTH{1'b0}};
            core_mod_r    <= {WIDTH{1'b0}};
            output_text_r <= {WIDTH{1'b0}};
            tx_shift_r    <= {WIDTH{1'b0}};
            tx_idx_r      <= {IDX_W{1'b0}};
            tx_valid_r    <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.rx_valid && go) begin
                        frame_r    <= {frame_r[3*WIDTH-9:0], bus.rx_data};
                        byte_cnt_r <= 4'd1;
                        done_r     <= 1'b0;
                        error_r    <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (bus.rx_valid) begin
                        frame_r    <= {frame_r[3*WIDTH-9:0], bus.rx_data};
                        byte_cnt_r <= byte_cnt_r + 4'd1;
                    end else if (gap_expire_s) begin
                        byte_cnt_r <= 4'd0;
                        error_r    <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (operand_bad_s) begin
                        error_r       <= 1'b1;
                        output_text_r <= {WIDTH{1'b1}};
                        tx_shift_r    <= {WIDTH{1'b1}};
                        tx_idx_r      <= {IDX_W{1'b0}};
                        tx_valid_r    <= 1'b1;
                    end else begin
                        core_msg_r   <= frame_m_s;
                        core_exp_r   <= frame_e_s;
                        core_mod_r   <= frame_n_s;
                        core_start_r <= 1'b1;
                    end
                end
                ST_START: begin
                    core_start_r <= 1'b0;
                end
                ST_WAIT: begin
                    if (bus.core_done) begin
                        output_text_r <= bus.core_result;
                        tx_shift_r    <= bus.core_result;
                        tx_idx_r      <= {IDX_W{1'b0}};
                        tx_valid_r    <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (tx_valid_r && bus.tx_ready) begin
                        tx_shift_r <= {tx_shift_r[WIDTH-9:0], 8'h00};
                        tx_idx_r   <= tx_idx_r + IDX_W'(1);
                        if (tx_idx_r == LAST_TX) begin
                            tx_valid_r <= 1'b0;
                            done_r     <= 1'b1;
                        end
                    end
                end
                default: begin
                    core_start_r <= 1'b0;
                    tx_valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.core_start = core_start_r;
    assign bus.core_msg   = core_msg_r;
    assign bus.core_exp   = core_exp_r;
    assign bus.core_mod   = core_mod_r;
    assign bus.tx_valid   = tx_valid_r;
    assign bus.tx_data    = tx_shift_r[WIDTH-1 -: 8];
    assign output_text    = output_text_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign error          = error_r;

endmodule

// File: tb/tb_rsa_frame_sequencer.sv
// Self-checking bench for rsa_frame_sequencer: random frames, a modexp core
// model, backpressure, timeout, reset during WAIT and ignored strobes.
// Expected core operands and tx bytes go into queues; a monitor pops them.
module tb_rsa_frame_sequencer;

    localparam int W  = 32;
    localparam int TO = 40;
`ifdef RSA_OPERAND_CHECK_EN
    localparam bit REJECT_EN = 1'b1;
`else
    localparam bit REJECT_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] m;
        logic [31:0] e;
        logic [31:0] n;
    } op_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         go;
    logic [W-1:0] output_text;
    logic         busy;
    logic         done;
    logic         error;

    always #5 clk = ~clk;

    rsa_frame_sequencer_if #(.WIDTH(W)) bus ();

    rsa_frame_sequencer #(
        .WIDTH         (W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .bus        (bus),
        .output_text(output_text),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    op_t         exp_core_q[$];
    logic [7:0]  exp_tx_q[$];
    logic        rx_last = 1'b0;
    int          stall_n = 0;
    int          stall_cnt = 0;
    bit          core_hold = 1'b0;
    int          core_delay_min = 1;
    int          core_delay_max = 6;
    int          n_starts = 0;
    logic [31:0] cur_m = 32'd0, cur_e = 32'd0, cur_n = 32'd0;
    int          t12 = 0;
    int          done_cyc = 0;
    bit          lat_arm = 1'b0;
    logic        prev_tx_valid = 1'b0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    // Reference: M^E mod N by square-and-multiply on 64-bit integers.
    function automatic logic [31:0] modexp(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n);
        longint unsigned r, b, nn;
        if (n == 32'd0) return 32'd0;
        nn = n;
        r  = 64'd1 % nn;
        b  = m % nn;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[31:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: checks core operands, latencies and every offered tx byte.
    initial begin : monitor
        op_t o;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.rx_valid && rx_last) t12 = cyc;
                if (bus.core_start) begin
                    n_starts++;
                    check("core_start_expected", exp_core_q.size() != 0, 1'b1);
                    if (exp_core_q.size() != 0) begin
                        o = exp_core_q.pop_front();
                        check("core_msg", bus.core_msg, o.m);
                        check("core_exp", bus.core_exp, o.e);
                        check("core_mod", bus.core_mod, o.n);
                        check("start_latency", cyc - t12, 2);
                        cur_m = o.m; cur_e = o.e; cur_n = o.n;
                    end
                end
                if (bus.core_done && busy) begin
                    lat_arm  = 1'b1;
                    done_cyc = cyc;
                end
                if (bus.tx_valid) begin
                    if (!prev_tx_valid && lat_arm) begin
                        check("tx_latency", cyc - done_cyc, 1);
                        lat_arm = 1'b0;
                    end
                    check("tx_expected", exp_tx_q.size() != 0, 1'b1);
                    if (exp_tx_q.size() != 0) begin
                        check("tx_data", bus.tx_data, exp_tx_q[0]);
                        if (bus.tx_ready) void'(exp_tx_q.pop_front());
                    end
                end
                prev_tx_valid = bus.tx_valid;
            end
        end
    end

    // Modexp core model: answers each start after a random delay.
    initial begin : core_model
        logic [31:0] m, e, n;
        int d;
        forever begin
            @(negedge clk);
            #1;
            if (bus.core_start && !core_hold) begin
                m = bus.core_msg; e = bus.core_exp; n = bus.core_mod;
                d = $urandom_range(core_delay_min, core_delay_max);
                repeat (d) begin @(posedge clk); #1; end
                check("held_msg", bus.core_msg, cur_m);
                check("held_exp", bus.core_exp, cur_e);
                check("held_mod", bus.core_mod, cur_n);
                bus.core_result = modexp(m, e, n);
                bus.core_done   = 1'b1;
                @(posedge clk); #1;
                bus.core_done   = 1'b0;
                bus.core_result = $urandom;
            end
        end
    end

    // uart_tx model: holds tx_ready low stall_n cycles per offered byte.
    initial begin : tx_sink
        bus.tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.tx_valid) begin
                if (stall_cnt >= stall_n) begin
                    bus.tx_ready = 1'b1;
                    stall_cnt    = 0;
                end else begin
                    bus.tx_ready = 1'b0;
                    stall_cnt++;
                end
            end else begin
                bus.tx_ready = 1'b0;
                stall_cnt    = 0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit last);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        rx_last      = last;
        tick(1);
        bus.rx_valid = 1'b0;
        rx_last      = 1'b0;
    endtask

    task automatic expect_frame(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n,
                                output bit rej, output logic [31:0] res);
        op_t o;
        rej = REJECT_EN && ((n == 32'd0) || (m >= n));
        if (rej) begin
            res = 32'hFFFF_FFFF;
        end else begin
            o.m = m; o.e = e; o.n = n;
            exp_core_q.push_back(o);
            res = modexp(m, e, n);
        end
        for (int i = 0; i < 4; i++) exp_tx_q.push_back(res[31-8*i -: 8]);
    endtask

    task automatic send_bytes(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n,
                              input int maxgap, input bit drop_go);
        logic [95:0] frame;
        frame = {m, e, n};
        for (int i = 0; i < 12; i++) begin
            drive_byte(frame[95-8*i -: 8], i == 11);
            if (drop_go && i == 0) go = 1'b0;
            tick($urandom_range(0, maxgap));
        end
        go = 1'b1;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 3000 && done !== 1'b1; k++) tick(1);
        check(name, done, 1'b1);
    endtask

    task automatic run_frame(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n,
                             input int maxgap, input bit drop_go);
        bit rej;
        logic [31:0] res;
        expect_frame(m, e, n, rej, res);
        send_bytes(m, e, n, maxgap, drop_go);
        wait_done("frame_done");
        check("frame_error", error, rej);
        check("frame_text", output_text, res);
        check("frame_busy", busy, 1'b0);
        check("tx_drained", exp_tx_q.size(), 0);
        check("core_drained", exp_core_q.size(), 0);
    endtask

    initial begin : driver
        int s0;
        logic [31:0] m, e, n;
        bit rej;
        logic [31:0] res;
        reset = 1'b1; go = 1'b1;
        bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
        bus.core_done = 1'b0; bus.core_result = 32'd0;
        tick(3);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_text", output_text, 32'd0);
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_core_start", bus.core_start, 1'b0);
        reset = 1'b0;
        tick(2);

        // Nominal frame, then the same frame under heavy backpressure.
        run_frame(32'd5, 32'd3, 32'h21, 0, 1'b0);
        check("nominal_text", output_text, 32'h0000_001A);
        stall_n = 7;
        run_frame(32'd5, 32'd3, 32'h21, 2, 1'b0);
        check("bp_text", output_text, 32'h0000_001A);
        stall_n = 0;

        // Random valid frames with random gaps, stalls and go dropping.
        for (int i = 0; i < 20; i++) begin
            n = $urandom_range(2, 32'hFFFF_FFFF);
            m = $urandom % n;
            e = $urandom;
            stall_n = $urandom_range(0, 3);
            run_frame(m, e, n, 5, ($urandom_range(0, 3) == 0));
        end
        stall_n = 0;

        // Timeout: five bytes, then silence.
        s0 = n_starts;
        for (int i = 0; i < 5; i++) begin
            drive_byte(8'($urandom), 1'b0);
            tick(1);
        end
        tick(TO + 10);
        check("timeout_error", error, 1'b1);
        check("timeout_busy", busy, 1'b0);
        check("timeout_no_start", n_starts, s0);
        run_frame(32'd7, 32'd11, 32'd101, 3, 1'b0);

        // Reset while waiting on the core, then a stray core_done.
        core_hold = 1'b1;
        expect_frame(32'd9, 32'd5, 32'd77, rej, res);
        exp_tx_q.delete();
        s0 = n_starts;
        send_bytes(32'd9, 32'd5, 32'd77, 1, 1'b0);
        for (int k = 0; k < 100 && n_starts == s0; k++) tick(1);
        check("rstwait_started", n_starts, s0 + 1);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rstwait_core_start", bus.core_start, 1'b0);
        check("rstwait_msg", bus.core_msg, 32'd0);
        check("rstwait_exp", bus.core_exp, 32'd0);
        check("rstwait_mod", bus.core_mod, 32'd0);
        check("rstwait_text", output_text, 32'd0);
        check("rstwait_busy", busy, 1'b0);
        check("rstwait_done", done, 1'b0);
        check("rstwait_error", error, 1'b0);
        bus.core_result = $urandom;
        bus.core_done   = 1'b1;
        tick(1);
        bus.core_done   = 1'b0;
        tick(6);
        check("rstwait_tx_valid", bus.tx_valid, 1'b0);
        check("rstwait_busy_after", busy, 1'b0);
        core_hold = 1'b0;

        // Strobes with go low in IDLE must not start a frame.
        go = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_byte(8'($urandom), 1'b0);
            check("go_low_busy", busy, 1'b0);
        end
        go = 1'b1;
        run_frame(32'd5, 32'd3, 32'h21, 0, 1'b0);

        // Strobes during WAIT and SEND are ignored.
        core_delay_min = 20; core_delay_max = 40; stall_n = 7;
        expect_frame(32'd123, 32'd65537, 32'd1000003, rej, res);
        s0 = n_starts;
        send_bytes(32'd123, 32'd65537, 32'd1000003, 0, 1'b0);
        for (int k = 0; k < 100 && n_starts == s0; k++) tick(1);
        check("ign_started", n_starts, s0 + 1);
        tick(2);
        for (int i = 0; i < 3; i++) drive_byte(8'($urandom), 1'b0);
        for (int k = 0; k < 200 && bus.tx_valid !== 1'b1; k++) tick(1);
        check("ign_tx_seen", bus.tx_valid, 1'b1);
        for (int i = 0; i < 2; i++) drive_byte(8'($urandom), 1'b0);
        wait_done("ign_done");
        check("ign_text", output_text, res);
        tick(3);
        check("ign_busy_after", busy, 1'b0);
        check("ign_tx_drained", exp_tx_q.size(), 0);
        core_delay_min = 1; core_delay_max = 6; stall_n = 0;

`ifdef RSA_OPERAND_CHECK_EN
        // Rejected operands: N==0 and M>=N.
        s0 = n_starts;
        run_frame(32'd5, 32'd3, 32'd0, 1, 1'b0);
        check("rej0_text", output_text, 32'hFFFF_FFFF);
        stall_n = 2;
        run_frame(32'h40, 32'd3, 32'h21, 1, 1'b0);
        check("rej1_error", error, 1'b1);
        check("rej_no_start", n_starts, s0);
        stall_n = 0;
`endif

        run_frame(32'd2, 32'd10, 32'd1025, 2, 1'b0);
        tick(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_frame_sequencer.md
Name: rsa_frame_sequencer

Overview:
Sequences one RSA modular-exponentiation transaction for the rfid board. It collects a 12-byte operand frame from the UART receiver's byte stream and splits it into message M, exponent E and modulus N. It then starts the modexp core, waits for its result, and returns the 32-bit result as 4 bytes through the UART transmitter. It sits between uart_rx/uart_tx and the modexp core and drives output_text for the seven-segment display logic.

Parameters:
WIDTH, 32, operand/result width in bits (must be a multiple of 8)
BYTES, WIDTH/8, bytes per field (derived; not overridden)
TIMEOUT_CYCLES, 1_000_000, max idle clk cycles between frame bytes (20 ms at 50 MHz)

Ports:
clk  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
go  in  1  enable; frames are accepted only while high
rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
rx_data  in  8  received byte
core_start  out  1  one-cycle start pulse to the modexp core
core_msg  out  WIDTH  M operand, held stable from core_start until core_done
core_exp  out  WIDTH  E operand, held stable from core_start until core_done
core_mod  out  WIDTH  N operand, held stable from core_start until core_done
core_done  in  1  one-cycle strobe, core_result valid
core_result  in  WIDTH  modexp result
tx_valid  out  1  byte offer to uart_tx
tx_data  out  8  byte to transmit
tx_ready  in  1  uart_tx accepts a byte when tx_valid && tx_ready
output_text  out  WIDTH  last result, held for display
busy  out  1  high in every state except IDLE
done  out  1  sticky; high after the last result byte is accepted
error  out  1  sticky; high after a frame timeout (also after an operand reject when the optional feature is on)

Behaviour:
- Reset (synchronous, active-high) drives all outputs to 0, clears all counters, and puts the FSM in IDLE. Reset wins over every other event and aborts any operation in progress.
- Frame format, in byte order: M, E, N, BYTES each, every field MSB-first. A frame is BYTES*3 bytes (12 at the default width).
- FSM states: IDLE, RECV, CHECK, START, WAIT, SEND.
- IDLE:
  - rx_valid && go: store the byte, set byte_cnt=1, clear done and error, go to RECV.
  - rx_valid with go low: ignore the byte.
- RECV:
  - Each rx_valid shifts in one byte and increments byte_cnt, then clears the gap counter.
  - When byte_cnt reaches 12 on a strobe, go to CHECK on the next cycle.
  - If the gap counter reaches TIMEOUT_CYCLES before the next byte: set error, discard the frame, go to IDLE.
  - go falling while in RECV does not abort the frame.
- CHECK: one cycle, then START (see Optional Feature).
- START: core_start=1 for exactly one cycle, then WAIT. Operands are registered and stay stable until core_done.
- WAIT:
  - Ignore all rx_valid strobes; no queuing.
  - On core_done, latch core_result into output_text and a 4-byte shift register, set tx index=0, go to SEND.
  - No timeout applies in WAIT.
- SEND:
  - Present result bytes MSB-first.
  - tx_valid stays high until the handshake completes; tx_data must not change while tx_valid && !tx_ready.
  - Each handshake advances the index. After the 4th handshake, drop tx_valid, set done, go to IDLE.
  - rx_valid is ignored in SEND.
- Latency: core_start asserts 2 cycles after the 12th rx_valid. The first tx_valid asserts 1 cycle after core_done.
- Simultaneous events:
  - rx_valid on the same cycle the gap counter reaches TIMEOUT_CYCLES: the byte wins and the counter clears.
  - core_done in any state other than WAIT is ignored.
- Width rules: shifting is byte-wide. byte_cnt is 4 bits, sized for up to 15 bytes; values 12..15 never occur in RECV. The gap counter saturates and does not wrap.

Optional Feature:
- Macro: RSA_OPERAND_CHECK_EN.
- Defined: in CHECK, if N==0 or M>=N, skip the core, set error, load output_text and the tx shift register with all-ones, and go directly to SEND. The 4 bytes FF FF FF FF are sent and done is set.
- Undefined: CHECK always goes to START. The error flag is driven only by timeout.

Decomposition:
- Package rsa_seq_pkg holds:
  - the state enum typedef;
  - FRAME_BYTES = 12 and RESULT_BYTES = 4;
  - the default WIDTH;
  - the all-ones ERROR_WORD constant.
- One sub-module is natural: rsa_byte_gap_timer, the saturating gap counter with clear and expire outputs.
- Frame assembly and the tx serializer stay inline.

Test Plan:
- Nominal: send 00 00 00 05 00 00 00 03 00 00 00 21 (M=5, E=3, N=33). Core model returns 0x1A. Expected: core_start 2 cycles after the 12th byte with msg=5, exp=3, mod=0x21; tx emits 00 00 00 1A; output_text=0x0000001A; done=1, error=0.
- Backpressure: as nominal, with tx_ready low for 7 cycles per byte. Expected: tx_data stable while stalled, byte order unchanged, exactly 4 handshakes.
- Timeout: send 5 bytes, then idle for TIMEOUT_CYCLES+10. Expected: error=1, busy=0, no core_start. A following valid 12-byte frame completes normally and clears error.
- Reset mid-WAIT: assert reset for 1 cycle while waiting on the core, then pulse core_done. Expected: all outputs 0, no tx_valid, FSM in IDLE.
- Ignore during WAIT and when disabled: rx_valid strobes in WAIT and with go=0 in IDLE. Expected: no byte_cnt change and no frame start.
- RSA_OPERAND_CHECK_EN: frame with N=0 or M=0x40, N=0x21. Expected: no core_start, tx emits FF FF FF FF, error=1, done=1.
